// File: rtl/ingress_packer.sv
// ingress_packer
// Per-port ingress stage of the shared-cache switch. Words arrive from the
// local port as {destination, data} over a valid/ready handshake. Each word
// is buffered, formatted into the fabric word {valid, rx_port, tx_port, data}
// and held on out_port until the fabric grants it. Words addressed to this
// port itself, or to a port that does not exist, are dropped and counted.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   local side offers a word
//   in_ready   packer can accept a word this cycle
//   in_dest    destination port index (becomes rx_port)
//   in_data    payload
//   out_port   fabric word {valid, rx_port, tx_port, data}; all zeros when idle
//   out_grant  fabric consumes the current out_port word this cycle
//   level      words held (FIFO + output register)
//   drop_cnt   saturating count of dropped words
module ingress_packer #(
   parameter int PORT_ID        = 0,
   parameter int PORT_NUB_TOTAL = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int FIFO_DEPTH     = 4,
   localparam int WIDTH_SEL     = $clog2(PORT_NUB_TOTAL),
   localparam int LEVEL_W       = $clog2(FIFO_DEPTH + 2)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [WIDTH_SEL-1:0]                in_dest,
   input  logic [DATA_WIDTH-1:0]               in_data,
   output logic [1+2*WIDTH_SEL+DATA_WIDTH-1:0] out_port,
   input  logic                                out_grant,
   output logic [LEVEL_W-1:0]                  level,
   output logic [7:0]                          drop_cnt
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int ENTRY_W = WIDTH_SEL + DATA_WIDTH;

   localparam logic [WIDTH_SEL-1:0] PORT_SEL  = WIDTH_SEL'(PORT_ID);
   localparam logic [WIDTH_SEL:0]   NUB_LIMIT = (WIDTH_SEL + 1)'(PORT_NUB_TOTAL);
   localparam logic [CNT_W-1:0]     CNT_FULL  = CNT_W'(FIFO_DEPTH);

   logic [ENTRY_W-1:0]   r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_rdPtr;
   logic [PTR_W-1:0]     r_wrPtr;
   logic [CNT_W-1:0]     r_count;
   logic                 r_orValid;
   logic [WIDTH_SEL-1:0] r_orDest;
   logic [DATA_WIDTH-1:0] r_orData;
   logic [LEVEL_W-1:0]   r_level;
   logic [7:0]           r_dropCnt;

   logic                 w_accept;
   logic                 w_drop;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_orFree;
   logic                 w_fifoToOr;
   logic                 w_bypass;
   logic                 w_fifoWr;
   logic                 w_nextOrValid;
   logic [CNT_W-1:0]     w_nextCount;
   logic [ENTRY_W-1:0]   w_fifoHead;

   // Ready is decided from the FIFO count alone so that neither out_grant nor
   // in_valid can ripple through to the handshake; it is held low during reset.
   assign in_ready = !rst && (r_count < CNT_FULL);

   // The idle word must be all zeros because the downstream destination
   // filters decode every bit of it, not just the valid flag.
   assign out_port = r_orValid ? {1'b1, r_orDest, PORT_SEL, r_orData} : '0;
   assign level    = r_level;
   assign drop_cnt = r_dropCnt;
   assign w_fifoHead = r_fifo[r_rdPtr];

   // Decide where an incoming word goes and whether the output register is
   // refilled. The output register is never left empty while the FIFO holds
   // data, so a fresh word only bypasses the FIFO when both are draining.
   always_comb begin
      w_accept      = in_valid && in_ready;
      w_drop        = w_accept && ((in_dest == PORT_SEL) || ({1'b0, in_dest} >= NUB_LIMIT));
      w_push        = w_accept && !w_drop;
      w_pop         = r_orValid && out_grant;
      w_orFree      = !r_orValid || w_pop;
      w_fifoToOr    = w_orFree && (r_count != '0);
      w_bypass      = w_orFree && (r_count == '0) && w_push;
      w_fifoWr      = w_push && !w_bypass;
      w_nextOrValid = w_fifoToOr || w_bypass || (r_orValid && !w_pop);
      w_nextCount   = r_count;
      if (w_fifoWr && !w_fifoToOr) begin
         w_nextCount = r_count + CNT_W'(1);
      end else if (w_fifoToOr && !w_fifoWr) begin
         w_nextCount = r_count - CNT_W'(1);
      end
   end

   // FIFO storage needs no reset: the count and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_fifoWr) begin
         r_fifo[r_wrPtr] <= {in_dest, in_data};
      end
   end

   // Pointer, count, output register and status bookkeeping. Pointers wrap
   // naturally because the depth is a power of two; fullness comes from the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdPtr   <= '0;
         r_wrPtr   <= '0;
         r_count   <= '0;
         r_orValid <= 1'b0;
         r_orDest  <= '0;
         r_orData  <= '0;
         r_level   <= '0;
         r_dropCnt <= '0;
      end else begin
         if (w_fifoWr) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_fifoToOr) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         r_count   <= w_nextCount;
         r_orValid <= w_nextOrValid;
         if (w_fifoToOr) begin
            r_orDest <= w_fifoHead[ENTRY_W-1:DATA_WIDTH];
            r_orData <= w_fifoHead[DATA_WIDTH-1:0];
         end else if (w_bypass) begin
            r_orDest <= in_dest;
            r_orData <= in_data;
         end
         r_level <= LEVEL_W'(w_nextCount) + LEVEL_W'(w_nextOrValid);
         if (w_drop && (r_dropCnt != 8'hFF)) begin
            r_dropCnt <= r_dropCnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_ingress_packer.sv
// tb_ingress_packer
// Self-checking bench for ingress_packer (PORT_ID=2, 8 ports, 32-bit data,
// FIFO depth 4). A reference model holds every stored word in a single queue
// in acceptance order; the head of that queue is what the fabric should see.
// Directed scenarios are followed by a randomized phase with occasional resets.
module tb_ingress_packer;

   localparam int PORT_ID = 2;
   localparam int DEPTH   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [2:0]  inDest = '0;
   logic [31:0] inData = '0;
   logic [38:0] outPort;
   logic        outGrant = 1'b0;
   logic [2:0]  level;
   logic [7:0]  dropCnt;

   int checks = 0;
   int errors = 0;

   logic [34:0] modelQ [$];
   int          modelDrops = 0;
   bit          lastAcc = 0;

   ingress_packer #(
      .PORT_ID(PORT_ID),
      .PORT_NUB_TOTAL(8),
      .DATA_WIDTH(32),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(inValid),
      .in_ready(inReady),
      .in_dest(inDest),
      .in_data(inData),
      .out_port(outPort),
      .out_grant(outGrant),
      .level(level),
      .drop_cnt(dropCnt)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs at the falling edge, compares every output
   // against the model, then advances the model across the rising edge.
   task automatic applyStimulus(input logic v, input logic [2:0] d, input logic [31:0] dat,
                                input logic g, input logic r);
      logic [38:0] expPort;
      bit          expReady;
      bit          acc;
      @(negedge clk);
      inValid  = v;
      inDest   = d;
      inData   = dat;
      outGrant = g;
      rst      = r;
      #1;
      expPort  = '0;
      if (modelQ.size() > 0) expPort = {1'b1, modelQ[0][34:32], 3'(PORT_ID), modelQ[0][31:0]};
      expReady = !r && (modelQ.size() <= DEPTH);
      checkOutput("out_port", 64'(outPort), 64'(expPort));
      checkOutput("in_ready", 64'(inReady), 64'(expReady));
      checkOutput("level", 64'(level), 64'(modelQ.size()));
      checkOutput("drop_cnt", 64'(dropCnt), 64'(modelDrops));
      @(posedge clk);
      acc = 0;
      if (r) begin
         modelQ.delete();
         modelDrops = 0;
      end else begin
         acc = v && expReady;
         if (g && modelQ.size() > 0) void'(modelQ.pop_front());
         if (acc) begin
            if (d == 3'(PORT_ID)) begin
               if (modelDrops < 255) modelDrops++;
            end else begin
               modelQ.push_back({d, dat});
            end
         end
      end
      lastAcc = acc;
   endtask

   // Grants until the model reports an empty packer.
   task automatic drain();
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, 0);
   endtask

   initial begin
      int k;
      logic [2:0] rd;
      // Power-up reset: outputs are undefined until the first reset edge.
      repeat (2) @(posedge clk);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);

      // Single word with an idle grant held high.
      applyStimulus(1, 3'd5, 32'hDEADBEEF, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("single_word_gone", 64'(outPort), 64'd0);

      // Backpressure: six distinct words offered, grant withheld for a while.
      k = 0;
      for (int c = 0; c < 20 && k < 6; c++) begin
         applyStimulus(1, 3'd3, 32'hA000_0000 + k, c >= 7, 0);
         if (lastAcc) k++;
      end
      checkOutput("backpressure_all_accepted", 64'(k), 64'd6);
      drain();

      // Self-addressed drop then a normal word to port 0.
      applyStimulus(1, 3'(PORT_ID), 32'h1111_1111, 0, 0);
      applyStimulus(1, 3'd0, 32'h2222_2222, 0, 0);
      applyStimulus(0, 0, 0, 1, 0);
      drain();

      // Drop counter saturation.
      for (int i = 0; i < 300; i++) applyStimulus(1, 3'(PORT_ID), 32'(i), 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("drop_saturated", 64'(dropCnt), 64'd255);

      // Reset with three words held.
      for (int i = 0; i < 3; i++) applyStimulus(1, 3'd4, 32'hC0 + i, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(1, 3'd7, 32'h7777_7777, 0, 0);
      applyStimulus(0, 0, 0, 1, 0);
      drain();

      // Streaming: one word per cycle with grant held high.
      for (int i = 0; i < 20; i++) applyStimulus(1, 3'd6, 32'h5000 + i, 1, 0);
      drain();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 2000; i++) begin
         rd = 3'($urandom_range(0, 7));
         applyStimulus(1'($urandom_range(0, 3) != 0), rd, $urandom,
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
